// File: rtl/uart_tx_cfg_pkg.sv
// Shared types and helpers for the runtime-configurable UART transmitter.
// Optional break support is enabled by defining UART_TX_BREAK_EN.
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [1:0] {
        STOP_1   = 2'd0,
        STOP_1P5 = 2'd1,
        STOP_2   = 2'd2
    } stop_e;

    // Raw cfg_parity code to parity mode; code 11 behaves as "none".
    function automatic parity_e decode_parity(logic [1:0] code);
        case (code)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    // Raw cfg_stop code to stop length; codes 10 and 11 both mean two stop bits.
    function automatic stop_e decode_stop(logic [1:0] code);
        case (code)
            2'b00:   return STOP_1;
            2'b01:   return STOP_1P5;
            default: return STOP_2;
        endcase
    endfunction

    // Number of s_tick periods the stop phase lasts.
    function automatic int stop_ticks(stop_e stop, int ovs);
        case (stop)
            STOP_1:   return ovs;
            STOP_1P5: return ovs + ovs / 2;
            default:  return 2 * ovs;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte handshake plus per-frame configuration between the TX FIFO and the transmitter.
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 8
);
    localparam int DBW = $clog2(DBIT_MAX + 1);

    logic                tx_valid;
    logic                tx_ready;
    logic [DBIT_MAX-1:0] tx_din;
    logic [DBW-1:0]      cfg_dbits;
    logic [1:0]          cfg_parity;
    logic [1:0]          cfg_stop;

    modport master (
        output tx_valid,
        output tx_din,
        output cfg_dbits,
        output cfg_parity,
        output cfg_stop,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_din,
        input  cfg_dbits,
        input  cfg_parity,
        input  cfg_stop,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_par_gen.sv
// Parity over the low dbits bits of a data word; odd=1 gives odd parity.
module uart_tx_par_gen #(
    parameter int DBIT_MAX = 8
) (
    input  logic [DBIT_MAX-1:0]            data,
    input  logic [$clog2(DBIT_MAX+1)-1:0]  dbits,
    input  logic                           odd,
    output logic                           parity
);

    logic [DBIT_MAX-1:0] mask;

    // Keep only the bit positions that are actually transmitted.
    generate
        for (genvar gi = 0; gi < DBIT_MAX; gi++) begin : g_mask
            assign mask[gi] = (int'(dbits) > gi);
        end
    endgenerate

    assign parity = (^(data & mask)) ^ odd;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data length, parity and stop length,
// paced by an external oversampling tick. Define UART_TX_BREAK_EN to add
// the tx_break input and the BREAK state.
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int OVS      = 16,
    parameter int DBIT_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_tick,
`ifdef UART_TX_BREAK_EN
    input  logic         tx_break,
`endif
    uart_tx_cfg_if.slave bus,
    output logic         tx,
    output logic         tx_done,
    output logic         tx_busy
);

    localparam int DBW = $clog2(DBIT_MAX + 1);
    localparam int SW  = $clog2(2 * OVS + 1);
    localparam int NW  = $clog2(DBIT_MAX);

    tx_state_e           state_reg;
    logic [SW-1:0]       s_cnt_reg;
    logic [NW-1:0]       n_cnt_reg;
    logic [DBIT_MAX-1:0] shift_reg;
    logic [DBW-1:0]      dbits_reg;
    parity_e             par_mode_reg;
    logic                par_bit_reg;
    logic [SW-1:0]       stop_len_reg;
    logic                tx_reg;
    logic                tx_done_reg;

    logic [DBW-1:0]      dbits_clamped;
    parity_e             par_mode_in;
    stop_e               stop_in;
    logic                par_bit_in;
    logic                tx_ready_int;
    logic                accept;
    logic                bit_end;
    logic                stop_end;
    logic                last_data_bit;
    logic                done_on_stop;

`ifdef UART_TX_BREAK_EN
    localparam int BRK_TICKS = OVS * (DBIT_MAX + 3);
    localparam int BRK_W     = $clog2(BRK_TICKS + 1);

    logic [BRK_W-1:0]    brk_cnt_reg;
    logic                brk_stop_reg;

    // A break request blocks new bytes while idle.
    assign tx_ready_int = (state_reg == IDLE) && !rst && !tx_break;
    // The stop period that closes a break is not a completed frame.
    assign done_on_stop = !brk_stop_reg;
`else
    assign tx_ready_int = (state_reg == IDLE) && !rst;
    assign done_on_stop = 1'b1;
`endif

    assign bus.tx_ready = tx_ready_int;
    assign accept       = bus.tx_valid && tx_ready_int;

    // Out-of-range lengths fall back to the widest frame.
    assign dbits_clamped = (bus.cfg_dbits < DBW'(5) || bus.cfg_dbits > DBW'(DBIT_MAX))
                         ? DBW'(DBIT_MAX) : bus.cfg_dbits;
    assign par_mode_in   = decode_parity(bus.cfg_parity);
    assign stop_in       = decode_stop(bus.cfg_stop);

    // Parity is computed once at acceptance from the unshifted byte.
    uart_tx_par_gen #(
        .DBIT_MAX (DBIT_MAX)
    ) u_par_gen (
        .data   (bus.tx_din),
        .dbits  (dbits_clamped),
        .odd    (par_mode_in == PAR_ODD),
        .parity (par_bit_in)
    );

    assign bit_end       = s_tick && (s_cnt_reg == SW'(OVS - 1));
    assign stop_end      = s_tick && (s_cnt_reg == stop_len_reg - SW'(1));
    assign last_data_bit = (DBW'(n_cnt_reg) == dbits_reg - DBW'(1));

    // Frame sequencer: state, bit/tick counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            s_cnt_reg    <= '0;
            n_cnt_reg    <= '0;
            shift_reg    <= '0;
            dbits_reg    <= '0;
            par_mode_reg <= PAR_NONE;
            par_bit_reg  <= 1'b0;
            stop_len_reg <= '0;
            tx_reg       <= 1'b1;
            tx_done_reg  <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt_reg  <= '0;
            brk_stop_reg <= 1'b0;
`endif
        end else begin
            tx_done_reg <= 1'b0;

            // Line level follows the state seen this cycle, one clock later.
            case (state_reg)
                START:   tx_reg <= 1'b0;
                DATA:    tx_reg <= shift_reg[0];
                PARITY:  tx_reg <= par_bit_reg;
                BREAK:   tx_reg <= 1'b0;
                default: tx_reg <= 1'b1;
            endcase

            case (state_reg)
                IDLE: begin
                    s_cnt_reg <= '0;
                    n_cnt_reg <= '0;
                    if (accept) begin
                        shift_reg    <= bus.tx_din;
                        dbits_reg    <= dbits_clamped;
                        par_mode_reg <= par_mode_in;
                        par_bit_reg  <= par_bit_in;
                        stop_len_reg <= SW'(stop_ticks(stop_in, OVS));
                        state_reg    <= START;
`ifdef UART_TX_BREAK_EN
                        brk_stop_reg <= 1'b0;
`endif
                    end
`ifdef UART_TX_BREAK_EN
                    else if (tx_break) begin
                        brk_cnt_reg <= '0;
                        state_reg   <= BREAK;
                    end
`endif
                end

                START: begin
                    if (bit_end) begin
                        s_cnt_reg <= '0;
                        n_cnt_reg <= '0;
                        state_reg <= DATA;
                    end else if (s_tick) begin
                        s_cnt_reg <= s_cnt_reg + SW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        s_cnt_reg <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (last_data_bit) begin
                            n_cnt_reg <= '0;
                            state_reg <= (par_mode_reg == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            n_cnt_reg <= n_cnt_reg + NW'(1);
                        end
                    end else if (s_tick) begin
                        s_cnt_reg <= s_cnt_reg + SW'(1);
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        s_cnt_reg <= '0;
                        state_reg <= STOP;
                    end else if (s_tick) begin
                        s_cnt_reg <= s_cnt_reg + SW'(1);
                    end
                end

                STOP: begin
                    if (stop_end) begin
                        s_cnt_reg   <= '0;
                        state_reg   <= IDLE;
                        tx_done_reg <= done_on_stop;
                    end else if (s_tick) begin
                        s_cnt_reg <= s_cnt_reg + SW'(1);
                    end
                end

`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (s_tick && brk_cnt_reg != BRK_W'(BRK_TICKS)) begin
                        brk_cnt_reg <= brk_cnt_reg + BRK_W'(1);
                    end
                    if (brk_cnt_reg == BRK_W'(BRK_TICKS) && !tx_break) begin
                        s_cnt_reg    <= '0;
                        stop_len_reg <= SW'(OVS);
                        brk_stop_reg <= 1'b1;
                        state_reg    <= STOP;
                    end
                end
`endif

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_reg;
    assign tx_done = tx_done_reg;
    assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table of frames plus hand-written
// back-to-back and reset-abort sequences, with a bit-sampling monitor.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

    localparam int OVS      = 16;
    localparam int DBIT_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_tick = 1'b0;
    logic tx;
    logic tx_done;
    logic tx_busy;
`ifdef UART_TX_BREAK_EN
    logic tx_break = 1'b0;
`endif

    uart_tx_cfg_if #(.DBIT_MAX(DBIT_MAX)) bus ();

    uart_tx_cfg #(
        .OVS      (OVS),
        .DBIT_MAX (DBIT_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tick   (s_tick),
`ifdef UART_TX_BREAK_EN
        .tx_break (tx_break),
`endif
        .bus      (bus),
        .tx       (tx),
        .tx_done  (tx_done),
        .tx_busy  (tx_busy)
    );

    typedef struct {
        logic [7:0]  din;
        logic [3:0]  dbits;
        logic [1:0]  par;
        logic [1:0]  stop;
        int          div;
        int          nbits;   // frame bits sampled, including stop samples
        logic [15:0] bits;    // expected line level per sampled bit, index 0 = start
        int          total;   // frame length in s_tick periods
    } vec_t;

    typedef struct {
        int          nbits;
        logic [15:0] bits;
        int          lo;
        int          hi;
    } frame_t;

    frame_t frame_q[$];
    vec_t   vecs[7];

    int n_checks    = 0;
    int n_fail      = 0;
    int frames_done = 0;
    int done_pulses = 0;
    int tick_div    = 1;
    int cyc         = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Oversampling tick: one clk wide, every tick_div-th clock.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph++;
            s_tick = (tick_div > 0) && (ph % tick_div == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on each start edge with a pending expected frame, sample each
    // bit at its centre and check the tx_done position.
    initial begin
        logic   prev_tx;
        frame_t fr;
        int     bclk;
        int     cnt;
        int     k;
        bit     seen;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_done === 1'b1) done_pulses++;
            if (tx === 1'b0 && prev_tx === 1'b1 && frame_q.size() > 0) begin
                fr   = frame_q.pop_front();
                bclk = OVS * tick_div;
                cnt  = 0;
                k    = 0;
                seen = 1'b0;
                while (!seen && cnt <= fr.hi + 4) begin
                    if (k < fr.nbits && cnt == bclk / 2 + k * bclk) begin
                        check($sformatf("frame%0d_bit%0d", frames_done, k), 32'(tx), 32'(fr.bits[k]));
                        k++;
                    end
                    @(negedge clk);
                    cnt++;
                    if (tx_done === 1'b1) begin
                        done_pulses++;
                        seen = 1'b1;
                    end
                end
                check($sformatf("frame%0d_bits_sampled", frames_done), k, fr.nbits);
                check($sformatf("frame%0d_done_seen", frames_done), 32'(seen), 32'd1);
                check($sformatf("frame%0d_done_time_%0d", frames_done, cnt),
                      32'(cnt >= fr.lo && cnt <= fr.hi), 32'd1);
                $display("frame %0d: %0d bits sampled, tx_done after %0d clks", frames_done, k, cnt);
                frames_done++;
            end
            prev_tx = tx;
        end
    end

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (bus.tx_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(bus.tx_ready), 32'd1);
    endtask

    task automatic send(input vec_t v);
        wait_ready("ready_before_send");
        bus.tx_din     = v.din;
        bus.cfg_dbits  = v.dbits;
        bus.cfg_parity = v.par;
        bus.cfg_stop   = v.stop;
        bus.tx_valid   = 1'b1;
        frame_q.push_back('{v.nbits, v.bits, (v.total - 1) * tick_div, v.total * tick_div - 1});
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("busy_after_accept", 32'(tx_busy), 32'd1);
        // Disturb inputs mid-frame; the latched frame must not change.
        bus.tx_din     = ~v.din;
        bus.cfg_dbits  = 4'd5;
        bus.cfg_parity = 2'b10;
        bus.cfg_stop   = 2'b00;
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames_done < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("frames_completed", frames_done, n);
    endtask

    initial begin
        int exp_frames;
        int t;
        int done_cyc;
        int pulses_before;

        exp_frames     = 0;
        bus.tx_valid   = 1'b0;
        bus.tx_din     = '0;
        bus.cfg_dbits  = 4'd8;
        bus.cfg_parity = 2'b00;
        bus.cfg_stop   = 2'b00;

        //        din    dbits  par    stop   div nbits bits       total
        vecs[0] = '{8'hA5, 4'd8,  2'b00, 2'b00, 1, 10, 16'h034A, 160}; // 8N1
        vecs[1] = '{8'hD3, 4'd7,  2'b01, 2'b00, 1, 10, 16'h02A6, 160}; // 7E1
        vecs[2] = '{8'h1F, 4'd5,  2'b10, 2'b10, 1,  9, 16'h01BE, 144}; // 5O2
        vecs[3] = '{8'h1F, 4'd5,  2'b10, 2'b11, 3,  9, 16'h01BE, 144}; // 5O2, slow tick
        vecs[4] = '{8'h3C, 4'd3,  2'b11, 2'b01, 1, 10, 16'h0278, 168}; // dbits clamped, 1.5 stop
        vecs[5] = '{8'h41, 4'd6,  2'b01, 2'b00, 1,  9, 16'h0182, 144}; // 6E1, masked parity
        vecs[6] = '{8'h80, 4'd12, 2'b01, 2'b10, 1, 12, 16'h0F00, 192}; // dbits clamped, 8E2

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.tx_ready), 32'd1);
        check("post_rst_busy", 32'(tx_busy), 32'd0);
        $display("reset: tx=%0b ready=%0b busy=%0b", tx, bus.tx_ready, tx_busy);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            tick_div = vecs[i].div;
            send(vecs[i]);
            exp_frames++;
            wait_frames(exp_frames);
        end
        tick_div = 1;

        // Back-to-back: valid held, second byte taken in the tx_done cycle
        wait_ready("b2b_ready_first");
        bus.tx_din     = 8'h55;
        bus.cfg_dbits  = 4'd8;
        bus.cfg_parity = 2'b00;
        bus.cfg_stop   = 2'b00;
        bus.tx_valid   = 1'b1;
        frame_q.push_back('{10, 16'h02AA, 159, 159});
        @(negedge clk);
        bus.tx_din = 8'h0F;
        frame_q.push_back('{10, 16'h021E, 159, 159});
        t = 0;
        while (bus.tx_ready !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done_with_ready", 32'(tx_done), 32'd1);
        check("b2b_ready_second", 32'(bus.tx_ready), 32'd1);
        done_cyc = cyc;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        t = 0;
        while (tx !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("b2b_start_gap", cyc - done_cyc, 2);
        $display("back-to-back: second start %0d clks after tx_done", cyc - done_cyc);
        exp_frames += 2;
        wait_frames(exp_frames);

        // Reset in the middle of data bit 3 of 0xFF: frame dropped, no tx_done
        wait_ready("abort_ready");
        bus.tx_din     = 8'hFF;
        bus.cfg_dbits  = 4'd8;
        bus.cfg_parity = 2'b00;
        bus.cfg_stop   = 2'b00;
        bus.tx_valid   = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        t = 0;
        while (tx !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_start_seen", 32'(tx), 32'd0);
        repeat (OVS + 3 * OVS + OVS / 2) @(negedge clk);
        check("abort_bit3_level", 32'(tx), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd1);
        pulses_before = done_pulses;
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_tx", 32'(tx), 32'd1);
        check("abort_rst_done", 32'(tx_done), 32'd0);
        check("abort_rst_ready", 32'(bus.tx_ready), 32'd0);
        check("abort_rst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_release_ready", 32'(bus.tx_ready), 32'd1);
        check("abort_release_busy", 32'(tx_busy), 32'd0);
        repeat (200) @(negedge clk);
        check("abort_no_done", done_pulses, pulses_before);
        check("abort_line_idle", 32'(tx), 32'd1);
        $display("reset abort: done pulses %0d -> %0d", pulses_before, done_pulses);

        // Fresh 8N1 frame of 0x00 after the abort
        send('{8'h00, 4'd8, 2'b00, 2'b00, 1, 10, 16'h0200, 160});
        exp_frames++;
        wait_frames(exp_frames);

        repeat (5) @(negedge clk);
        check("done_pulse_total", done_pulses, exp_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Next-generation UART transmitter. Supports data length, parity and stop length that are configurable at runtime per frame, and uses a valid/ready byte handshake. It is paced by an external oversampling tick, s_tick, from the shared baud generator. It sits between the TX FIFO read side and the serial pin.

Parameters:
OVS, 16, s_tick pulses per bit period (≥4, even)
DBIT_MAX, 8, maximum data bits; tx_din width (≥5)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
s_tick  in  1  oversampling tick, one clk wide
tx_valid  in  1  byte available
tx_ready  out  1  block can accept a byte
tx_din  in  DBIT_MAX  data, LSB transmitted first
cfg_dbits  in  $clog2(DBIT_MAX+1)  data bits per frame, legal 5..DBIT_MAX
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop  in  2  00 1 stop, 01 1.5 stop, 10/11 2 stop
tx  out  1  serial line, registered
tx_done  out  1  one-clk pulse at frame end
tx_busy  out  1  state != IDLE

Behaviour:
- One clock: clk. Reset is synchronous and active-high. While rst is high: state=IDLE, tx=1, tx_done=0, tx_ready=0, tx_busy=0, all counters and shift register cleared.
- Accept: a byte is accepted when tx_valid && tx_ready, which can only happen in IDLE. On acceptance:
  - tx_din, cfg_dbits, cfg_parity and cfg_stop are latched.
  - Config changes mid-frame have no effect.
  - cfg_dbits outside 5..DBIT_MAX is clamped to DBIT_MAX.
- tx_ready = (state==IDLE) && !rst.
- FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - START, DATA and PARITY each last OVS ticks. The state advances on s_tick when s_cnt==OVS-1.
  - s_cnt resets to 0 on every bit boundary and on acceptance.
  - DATA: n_cnt counts 0..dbits-1. The shift register shifts right at each bit boundary.
  - PARITY is skipped when parity is none.
  - STOP lasts OVS, OVS+OVS/2, or 2*OVS ticks, per latched cfg_stop.
- Parity is computed over the low dbits bits only (upper bits masked). Even: XOR reduction. Odd: its inverse.
- tx is registered from the current state with one clk latency: IDLE/STOP→1, START→0, DATA→shift_reg[0], PARITY→parity bit.
- tx_done: registered, high for exactly one clk on the clk after the s_tick that ends STOP. In that same cycle state is IDLE and tx_ready=1, so back-to-back acceptance is allowed.
- s_tick absent: all counters hold and tx holds.
- Reset mid-frame: frame is discarded, tx=1 on the next clk, no tx_done.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input tx_break and a BREAK state.
  - In IDLE, tx_break has priority over tx_valid and tx_ready is low.
  - In BREAK, tx=0 for at least OVS*(DBIT_MAX+3) ticks and until tx_break is low.
  - The block then enters STOP with one stop period (OVS ticks), then returns to IDLE.
  - No tx_done is produced for a break.
- Undefined: no port and no state; behaviour is exactly as above.

Decomposition:
- Package uart_tx_cfg_pkg:
  - enum tx_state_e {IDLE, START, DATA, PARITY, STOP, BREAK}
  - enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}
  - enum stop_e {STOP_1, STOP_1P5, STOP_2}
  - helper function stop_ticks(stop_e, OVS)
- Sub-module uart_tx_par_gen: masked parity from data and dbits. The FSM, counters and shift register stay in uart_tx_cfg.

Test Plan:
All scenarios use OVS=16, DBIT_MAX=8, and s_tick every clk unless noted.
1. Reset: rst=1 for 2 clk → tx=1, tx_done=0, tx_ready=0. After release: tx_ready=1, tx_busy=0.
2. 8N1, din=0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each 16 ticks. One tx_done pulse after the 160th tick.
3. 7E1, din=0xD3 → tx bits 0,1,1,0,0,1,0,1,0,1. Bit 7 is ignored and the parity bit is 0.
4. 5O2, din=0x1F → tx bits 0,1,1,1,1,1,0, then 32 stop ticks high. Repeat with s_tick every 3rd clk: 3× duration, identical bit sequence.
5. Back-to-back, tx_valid held high with 0x55 then 0x0F (8N1) → second byte accepted in the tx_done cycle. Second start bit begins 2 clk after first stop ends. Two tx_done pulses.
6. rst asserted at data bit 3 of 0xFF → tx=1 the next clk, no tx_done. tx_ready=1 after release, and a new frame 0x00 transmits correctly.
